// File: rtl/seg7_display_ctrl_pkg.sv
// Shared definitions for the seven-segment display controller:
// register map, segment bit order and the hex glyph table.
package seg7_display_ctrl_pkg;

  // IO register offsets (low address bits); offset 3 is unmapped.
  localparam logic [1:0] SEG_ADDR_LO   = 2'd0;
  localparam logic [1:0] SEG_ADDR_CTRL = 2'd1;
  localparam logic [1:0] SEG_ADDR_HI   = 2'd2;

  // Segment word as driven on seg_out: {dp,g,f,e,d,c,b,a}, bit 0 = a.
  typedef struct packed {
    logic       dp;
    logic [6:0] gfedcba;
  } seg_word_t;

  // Glyphs for 0-F in {g,f,e,d,c,b,a} order, active-high.
  localparam logic [6:0] HEX7_TABLE [0:15] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

endpackage

// File: rtl/hex_to_seg7.sv
// Combinational nibble-to-glyph decoder for one seven-segment digit.
module hex_to_seg7 (
  input  logic [3:0] i_nibble,
  output logic [6:0] o_seg
);
  import seg7_display_ctrl_pkg::*;

  assign o_seg = HEX7_TABLE[i_nibble];

endmodule

// File: rtl/seg7_display_ctrl.sv
// Memory-mapped 8-digit seven-segment controller. CPU writes land in a
// pending buffer; the buffer is copied to the displayed shadow copy only
// at the end of a full 8-digit frame, so a frame never shows a mix of
// old and new data. Digits are time-multiplexed by a prescaled scan
// counter with a short blanking window at the start of each slot.
module seg7_display_ctrl #(
  parameter int SCAN_DIV     = 100000,
  parameter int BLANK_CYCLES = 1000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        SegCtrl,
  input  logic        ioWrite,
  input  logic [1:0]  segAddr,
  input  logic [15:0] write_data,
  output logic [7:0]  seg_en,
  output logic [7:0]  seg_out,
  output logic        frame_done
);
  import seg7_display_ctrl_pkg::*;

  localparam int             CW        = $clog2(SCAN_DIV);
  localparam logic [CW-1:0]  CNT_LAST  = CW'(SCAN_DIV - 1);
  localparam logic [CW-1:0]  BLANK_LIM = CW'(BLANK_CYCLES);

  logic [CW-1:0] r_cnt;
  logic [2:0]    r_idx;
  logic [31:0]   r_pending;
  logic [31:0]   r_shadow;
  logic [7:0]    r_en_mask;
  logic [7:0]    r_dp_mask;
  logic          r_frame_done;
  logic [7:0]    r_seg_en;
  seg_word_t     r_seg_out;

  logic          w_wr;
  logic          w_slot_end;
  logic          w_commit;
  logic          w_blank;
  logic [3:0]    w_nibble;
  logic [6:0]    w_glyph;

  assign w_wr       = SegCtrl & ioWrite;
  assign w_slot_end = (r_cnt == CNT_LAST);
  assign w_commit   = w_slot_end && (r_idx == 3'd7);
  assign w_blank    = (r_cnt < BLANK_LIM) || !r_en_mask[r_idx];
  assign w_nibble   = r_shadow[{r_idx, 2'b00} +: 4];

  hex_to_seg7 u_hex (
    .i_nibble (w_nibble),
    .o_seg    (w_glyph)
  );

  // CPU register writes: data halves go to the pending buffer, masks apply at once.
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_pending <= '0;
      r_en_mask <= '0;
      r_dp_mask <= '0;
    end else if (w_wr) begin
      case (segAddr)
        SEG_ADDR_LO:   r_pending[15:0]  <= write_data;
        SEG_ADDR_HI:   r_pending[31:16] <= write_data;
        SEG_ADDR_CTRL: begin
          r_en_mask <= write_data[7:0];
          r_dp_mask <= write_data[15:8];
        end
        default: ;
      endcase
    end
  end

  // Scan prescaler, digit index and end-of-frame commit of pending into shadow.
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_cnt        <= '0;
      r_idx        <= '0;
      r_shadow     <= '0;
      r_frame_done <= 1'b0;
    end else begin
      if (w_slot_end) begin
        r_cnt <= '0;
        r_idx <= r_idx + 3'd1;
      end else begin
        r_cnt <= r_cnt + CW'(1);
      end
      // Reads the pre-edge pending value, so a same-cycle write waits a frame.
      if (w_commit) begin
        r_shadow <= r_pending;
      end
      r_frame_done <= w_commit;
    end
  end

  // Registered digit drive: dark during blanking or for masked digits, else one-hot.
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_seg_en  <= '0;
      r_seg_out <= '0;
    end else if (w_blank) begin
      r_seg_en  <= '0;
      r_seg_out <= '0;
    end else begin
      r_seg_en          <= 8'b1 << r_idx;
      r_seg_out.dp      <= r_dp_mask[r_idx];
      r_seg_out.gfedcba <= w_glyph;
    end
  end

  assign seg_en     = r_seg_en;
  assign seg_out    = r_seg_out;
  assign frame_done = r_frame_done;

endmodule

// File: doc/seg7_display_ctrl.md
Name: seg7_display_ctrl

Overview:
- Memory-mapped 8-digit seven-segment display controller on the CPU IO bus, alongside the LED and switch peripherals.
- Consumes IO writes from the memory/IO address decoder: chip select, ioWrite, low address bits and 16-bit write data.
- Holds a 32-bit hex value plus control masks, and time-multiplexes the 8 digits with a prescaled scan counter.
- Double-buffers display data so a frame never tears.

Parameters:
- SCAN_DIV, 100000, clock cycles per digit slot; must be >= 2.
- BLANK_CYCLES, 1000, cycles at the start of each slot with all digits off (anti-ghosting); must be < SCAN_DIV.

Ports:
- clock  in  1  CPU clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-low reset.
- SegCtrl  in  1  chip select from the IO address decoder.
- ioWrite  in  1  IO write strobe.
- segAddr  in  2  low address bits; selects the register.
- write_data  in  16  IO write data.
- seg_en  out  8  digit enables, active-high, one-hot or zero; bit i = digit i.
- seg_out  out  8  segments {dp,g,f,e,d,c,b,a}, active-high.
- frame_done  out  1  one-cycle pulse when a frame commit occurs.

Behaviour:
- Write strobe: wr = SegCtrl & ioWrite, sampled on the clock edge.
- Register map:
  - segAddr 0: pending[15:0] <= write_data.
  - segAddr 2: pending[31:16] <= write_data.
  - segAddr 1: en_mask <= write_data[7:0] and dp_mask <= write_data[15:8]; takes effect immediately.
  - segAddr 3: write ignored.
- Reset (reset==0 at an edge): cnt, idx, pending, shadow, en_mask, dp_mask all 0. Outputs seg_en=0, seg_out=0, frame_done=0. The display is dark until en_mask is written.
- Prescaler: cnt runs 0..SCAN_DIV-1.
  - At cnt==SCAN_DIV-1: cnt<=0 and idx<=idx+1, wrapping 7 to 0.
  - If idx==7 at that moment, commit: shadow<=pending and frame_done<=1 for one cycle. Otherwise frame_done<=0.
- Commit and write in the same cycle: shadow takes the OLD pending value. The new write lands in pending and is displayed after the next commit.
- Output stage, registered (one cycle after the cnt/idx values that produce it):
  - Blank condition: cnt < BLANK_CYCLES or en_mask[idx]==0.
  - When blank: seg_en<=0 and seg_out<=0.
  - Otherwise: seg_en<=(1<<idx) and seg_out<={dp_mask[idx], hex7(shadow[4*idx+3:4*idx])}.
- Hex decode, 7-bit {g..a}: 0:3F 1:06 2:5B 3:4F 4:66 5:6D 6:7D 7:07 8:7F 9:6F A:77 b:7C C:39 d:5E E:79 F:71.
- Width: the cnt width is clog2(SCAN_DIV). No arithmetic overflow is possible; idx is 3 bits with natural wrap.
- Reset mid-scan: reset takes priority over every write and commit that cycle. Scan restarts at idx 0, cnt 0.
- Boundaries:
  - en_mask==0: seg_en stays 0 forever, but scanning and commits continue (frame_done still pulses).
  - seg_en is never multi-hot.

Decomposition:
- Shared package holds:
  - register address constants SEG_ADDR_LO=0, SEG_ADDR_CTRL=1, SEG_ADDR_HI=2;
  - the hex-to-segment constant table;
  - the segment bit-order definition.
- One sub-module: hex_to_seg7 (combinational 4-bit to 7-bit decoder), instantiated once on the nibble selected by idx.

Test Plan (SCAN_DIV=4, BLANK_CYCLES=1):
- Reset: hold reset=0 for 3 cycles with writes active -> seg_en=0, seg_out=0, frame_done=0; after release, nothing lights until the ctrl register is written.
- Basic display: write addr0=0x3210, addr2=0x7654, addr1=0x00FF; wait one frame (32 cycles) past frame_done -> each slot shows seg_en=0x01 with seg_out=0x3F, then 0x02/0x06, ..., 0x80/0x07. seg_en=0 during the first cycle of each slot.
- Masks: ctrl=0x0505 with shadow=0x00000008 -> only digits 0 and 2 light. Digit 0 shows seg_out=0xFF (dp+8); digit 2 shows 0xBF (dp+0). Slots 1, 3-7 stay dark.
- Tear-free update: write addr0=0xFFFF mid-frame -> displayed nibbles unchanged until the frame_done pulse, then digits 0-3 show 0x71.
- Same-cycle write and commit: issue an addr2 write exactly on the commit edge -> the following frame shows the old high half; the new value appears after the next frame_done.
- Reset mid-scan and addr3: write addr3=0xFFFF -> no register changes. Assert reset while idx=5 -> next active slot after re-enabling starts at digit 0 with cnt=0.
